// File: rtl/apb_pkg.sv
// APB bus types shared by initiators, completers and benches.
package apb_pkg;

    typedef logic [2:0] prot_t;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = cf_math_pkg::ceil_div(DataWidth, 8);

    typedef enum logic {
        OKAY   = 1'b0,
        SLVERR = 1'b1
    } apb_resp_t;

endpackage

// File: rtl/cf_math_pkg.sv
// Small compile-time arithmetic helpers shared by the bus packages.
package cf_math_pkg;

    function automatic int unsigned ceil_div(input int unsigned dividend, input int unsigned divisor);
        return (dividend + divisor - 1) / divisor;
    endfunction

endpackage

// File: rtl/apb_wait_state_cnt.sv
// Access-phase wait-state counter; done is asserted once WaitCycles cycles have elapsed.
module apb_wait_state_cnt #(
    parameter int unsigned WaitCycles = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CntWidth = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(WaitCycles);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    assign done_o = (cnt_q == CntMax);

    // Completion wraps to 0 so a back-to-back transfer starts a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (done_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_regs_completer.sv
// APB4 completer exposing a bank of byte-strobed registers, with optional wait states,
// read-only words supplied by hardware and error responses on illegal accesses.
module apb_regs_completer
    import apb_pkg::*;
#(
    parameter int unsigned                  NoRegs     = 8,
    parameter int unsigned                  AddrWidth  = 32,
    parameter int unsigned                  DataWidth  = 32,
    parameter logic [AddrWidth-1:0]         BaseAddr   = '0,
    parameter int unsigned                  WaitCycles = 0,
    parameter logic [NoRegs-1:0]            ReadOnly   = '0,
    parameter logic [NoRegs*DataWidth-1:0]  ResetValue = '0,
    parameter bit                           PrivOnly   = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [AddrWidth-1:0]           paddr_i,
    input  prot_t                          pprot_i,
    input  logic                           psel_i,
    input  logic                           penable_i,
    input  logic                           pwrite_i,
    input  logic [DataWidth-1:0]           pwdata_i,
    input  logic [DataWidth/8-1:0]         pstrb_i,
    output logic                           pready_o,
    output logic [DataWidth-1:0]           prdata_o,
    output logic                           pslverr_o,
    output logic [NoRegs*DataWidth-1:0]    reg_q_o,
    input  logic [NoRegs*DataWidth-1:0]    reg_ro_i,
    output logic [NoRegs-1:0]              wr_pulse_o
);

    localparam int unsigned StrbW    = DataWidth / 8;
    localparam int unsigned IdxWidth = (NoRegs > 1) ? $clog2(NoRegs) : 1;
    localparam int unsigned AddrLsb  = (StrbW > 1) ? $clog2(StrbW) : 0;

    logic                  access;
    logic                  cnt_done;
    logic                  commit;
    logic [AddrWidth-1:0]  offset;
    logic [AddrWidth-1:0]  word_idx;
    logic                  below_base;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  in_range;
    logic                  ro_hit;
    logic                  priv_fail;
    logic                  err;
    logic [IdxWidth-1:0]   idx;
    logic [DataWidth-1:0]  rd_word;
    logic [DataWidth-1:0]  reg_word [NoRegs];
    logic [DataWidth-1:0]  ro_word  [NoRegs];
    logic [NoRegs-1:0]     wr_sel;
    logic [NoRegs-1:0]     wr_pulse_q, wr_pulse_d;
    logic                  prot_unused;

    // Only the privileged bit of pprot carries meaning for this block.
    assign prot_unused = ^pprot_i[2:1];

    assign access = psel_i & penable_i;

    apb_wait_state_cnt #(
        .WaitCycles (WaitCycles)
    ) u_wait_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (~access),
        .en_i    (access),
        .done_o  (cnt_done)
    );

    // Address decode; an address below the base wraps to a huge offset and is also out of range.
    always_comb begin
        offset       = paddr_i - BaseAddr;
        word_idx     = offset >> AddrLsb;
        below_base   = (paddr_i < BaseAddr);
        out_of_range = (word_idx >= AddrWidth'(NoRegs));
        misaligned   = ((offset & AddrWidth'(StrbW - 1)) != '0);
        in_range     = !below_base && !out_of_range;
        idx          = in_range ? word_idx[IdxWidth-1:0] : '0;
        ro_hit       = in_range && ReadOnly[idx];
        priv_fail    = PrivOnly && !pprot_i[0];
        err          = below_base | out_of_range | misaligned | (pwrite_i & ro_hit) | priv_fail;
        rd_word      = ro_hit ? ro_word[idx] : reg_word[idx];
    end

    assign pready_o  = access & cnt_done;
    assign pslverr_o = pready_o & err;
    assign prdata_o  = (pready_o && !err && !pwrite_i) ? rd_word : '0;
    assign commit    = pready_o & pwrite_i & ~err;

    for (genvar gi = 0; gi < NoRegs; gi++) begin : g_reg
        assign ro_word[gi] = reg_ro_i[gi*DataWidth +: DataWidth];
        assign wr_sel[gi]  = commit && (idx == IdxWidth'(gi));

        if (ReadOnly[gi]) begin : g_ro
            assign reg_word[gi] = ResetValue[gi*DataWidth +: DataWidth];
        end else begin : g_rw
            logic [DataWidth-1:0] data_q, data_d;

            always_comb begin
                data_d = data_q;
                if (wr_sel[gi]) begin
                    for (int b = 0; b < StrbW; b++) begin
                        if (pstrb_i[b]) begin
                            data_d[8*b +: 8] = pwdata_i[8*b +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    data_q <= ResetValue[gi*DataWidth +: DataWidth];
                end else begin
                    data_q <= data_d;
                end
            end

            assign reg_word[gi] = data_q;
        end

        assign reg_q_o[gi*DataWidth +: DataWidth] = reg_word[gi];
    end

    // An all-zero strobe completes normally but is not a register update.
    assign wr_pulse_d = wr_sel & {NoRegs{|pstrb_i}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: doc/apb_regs_completer.md
Name: apb_regs_completer

Overview:
- APB4 (v2.0) completer: a bank of memory-mapped 32-bit registers on the Slave side of an APB bus.
- Configurable wait states, byte strobes and read-only registers.
- Error response on unmapped, misaligned, read-only-write or unprivileged accesses.
- Counterpart to the team's APB initiators. Register contents are exported to surrounding logic; hardware supplies the read-only values.

Parameters:
- NoRegs, 8, number of registers (≥1).
- AddrWidth, 32, paddr width.
- DataWidth, 32, register/data width (multiple of 8).
- BaseAddr, 0, byte address of register 0 (aligned to DataWidth/8).
- WaitCycles, 0, pready deasserted for this many access-phase cycles.
- ReadOnly, '0, NoRegs-bit mask; bit i set → register i is read-only.
- ResetValue, '0, NoRegs*DataWidth reset image.
- PrivOnly, 0, if 1, accesses with pprot[0]==0 get an error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- paddr_i  in  AddrWidth  APB address
- pprot_i  in  3  apb_pkg::prot_t protection
- psel_i  in  1  select
- penable_i  in  1  enable
- pwrite_i  in  1  1=write
- pwdata_i  in  DataWidth  write data
- pstrb_i  in  DataWidth/8  write byte strobes
- pready_o  out  1  transfer complete
- prdata_o  out  DataWidth  read data
- pslverr_o  out  1  transfer error
- reg_q_o  out  NoRegs*DataWidth  current writable register contents
- reg_ro_i  in  NoRegs*DataWidth  values returned for read-only registers
- wr_pulse_o  out  NoRegs  one-cycle pulse on committed write to register i

Behaviour:
- Reset (async, rst_ni=0): registers ← ResetValue; wait counter ← 0; wr_pulse_o=0. pready_o, prdata_o and pslverr_o read 0 because psel is gated.
- Setup phase (psel=1, penable=0): no action. Counter held at 0.
- Access phase (psel=1, penable=1):
  - pready_o = (cnt_q == WaitCycles), combinational.
  - While not ready, cnt_q increments each cycle.
  - On the completing cycle, cnt_q ← 0.
  - WaitCycles=0 → pready in the first access cycle.
- psel=0 at any time: cnt_q ← 0. An abandoned transfer (psel dropped before pready) does not commit.
- Decode: offset = paddr − BaseAddr; idx = offset >> log2(DataWidth/8).
- Error conditions (evaluated in the access phase):
  - paddr < BaseAddr;
  - idx ≥ NoRegs;
  - offset low bits ≠ 0;
  - write to a ReadOnly register;
  - PrivOnly && !pprot[0].
- pslverr_o = pready_o && error. It is 0 whenever pready_o=0.
- Read: prdata_o = (ReadOnly[idx] ? reg_ro_i[idx] : reg_q[idx]) in the completing cycle when there is no error. Otherwise prdata_o = 0.
- Write: on the clock edge ending the completing cycle (psel&penable&pready, no error):
  - each byte b with pstrb[b]=1 is updated from pwdata;
  - wr_pulse_o[idx]=1 for the following cycle, only if pstrb≠0.
- Erroneous writes: no register change, no pulse.
- pstrb=0 write: completes OKAY with no change and no pulse.
- Back-to-back transfers (setup immediately after completion) are supported. The counter restarts from 0.
- Reset asserted mid-transfer: counter cleared; the transfer neither commits nor pulses.
- ReadOnly register storage is not instantiated; reg_q_o returns ResetValue for those bits.

Decomposition:
- Reuse apb_pkg::prot_t.
- Add to apb_pkg: the localparam for the strobe width (ceil_div via cf_math_pkg) and an apb_resp enumeration (OKAY/SLVERR) for benches.
- One natural sub-module: apb_wait_state_cnt.
  - Width $clog2(WaitCycles+1), min 1.
  - Inputs: clear, enable.
  - Output: done = (cnt==WaitCycles).
  - Instantiated once.

Test Plan:
- WaitCycles=0, write 0xDEADBEEF, pstrb=0xF to BaseAddr+0x4 → pready in the first access cycle, pslverr=0, reg_q_o[1]=0xDEADBEEF, wr_pulse_o=0b10 for one cycle. Read back → prdata=0xDEADBEEF.
- WaitCycles=3: read BaseAddr+0x0 → pready low for 3 access cycles, high on the 4th. prdata=ResetValue[0] only in that cycle, 0 before.
- Partial strobe: reg2=0x11223344, write 0xAABBCCDD with pstrb=0b0101 → reg2=0x11BB33DD.
- Errors:
  - write to ReadOnly reg 3 → pslverr=1, reg unchanged, no pulse;
  - read BaseAddr+4*NoRegs → pslverr=1, prdata=0;
  - paddr=BaseAddr+0x2 → pslverr=1;
  - PrivOnly=1 with pprot=0b000 → pslverr=1.
- Abort: WaitCycles=4, drop psel after 2 access cycles of a write to reg0 → no update. The next transfer still waits the full 4 cycles.
- Reset: rst_ni low during the wait-state countdown of a write → registers return to ResetValue, pready=0. After release, a fresh read completes normally.
